intdiv_ctrl: RTL and testbench
==============================

INTDIV_CTRL -- requirements
Module: intdiv_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning quotient width in bits and number of iterations (N >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new division; accepted only in IDLE.
REQ-005 SHALL have port divisor_zero  input  1  datapath flag for a zero divisor; sampled only when start is accepted.
REQ-006 SHALL have port q_digit  input  2  SD2 quotient digit from selection logic (11 = -1, 00 = 0, 01 = +1, 10 = +1); sampled every ITER cycle.
REQ-007 SHALL have port rem_sign  input  1  sign of the final partial remainder (1 = negative); sampled only in FIX.
REQ-008 SHALL have port load  output  1  datapath load strobe for operands.
REQ-009 SHALL have port iter_en  output  1  datapath iteration enable (shift/add-subtract step).
REQ-010 SHALL have port corr  output  1  remainder-correction strobe (add divisor back).
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port dbz  output  1  divide-by-zero flag for the last operation.
REQ-014 SHALL have port quotient  output  N  final binary (two's complement) quotient.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, ITER, FIX, DONE.
REQ-016 IDLE: start=1 and divisor_zero=0 -> LOAD; start=1 and divisor_zero=1 -> DONE; otherwise stay.
REQ-017 LOAD: load=1 for exactly one cycle; internal Q <= 0, QM <= all ones, step counter <= 0; -> ITER.
REQ-018 ITER: iter_en=1 for exactly N consecutive cycles; counter increments each cycle; -> FIX after the cycle with counter = N-1.
REQ-019 On-the-fly conversion each ITER cycle: digit +1 -> Q <= {Q[N-2:0],1}, QM <= {Q[N-2:0],0}; digit 0 -> Q <= {Q[N-2:0],0}, QM <= {QM[N-2:0],1}; digit -1 -> Q <= {QM[N-2:0],1}, QM <= {QM[N-2:0],0}.
REQ-020 Digit codes 01 and 10 SHALL be treated identically as +1.
REQ-021 FIX (one cycle): rem_sign=1 -> corr=1, quotient <= QM; rem_sign=0 -> corr=0, quotient <= Q; -> DONE.
REQ-022 DONE (one cycle): done=1; -> IDLE.
REQ-023 busy SHALL be 1 in LOAD, ITER, FIX and 0 in IDLE, DONE.
REQ-024 Latency: start accepted at edge 0 -> load in cycle 1, iter_en cycles 2..N+1, FIX cycle N+2, done cycle N+3.
REQ-025 Divide by zero: DONE entered in cycle 1; load, iter_en, corr never asserted; quotient <= all ones; dbz <= 1.
REQ-026 dbz SHALL be cleared to 0 on the next accepted start with divisor_zero=0 and otherwise hold.
REQ-027 quotient SHALL hold its value from FIX/dbz until the next FIX or dbz update.
REQ-028 start SHALL be ignored in LOAD, ITER, FIX and DONE; a start held high continuously SHALL launch a new operation only on return to IDLE.
REQ-029 load, iter_en, corr, done SHALL be registered outputs, mutually exclusive in any cycle.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force state IDLE, counter 0, Q 0, QM all ones, and load, iter_en, corr, busy, done, dbz, quotient all 0.
REQ-031 Reset asserted mid-operation SHALL abort it with no done pulse; after release the block SHALL wait in IDLE for start.

Verification (N=8)
REQ-032 digits +1 x8, rem_sign=0 -> quotient 0xFF, corr=0, done in cycle 11, exactly 8 iter_en cycles.
REQ-033 digits +1,-1,0,0,0,0,0,+1 (MSB first), rem_sign=0 -> quotient 0x41; same digits with rem_sign=1 -> quotient 0x40 and corr=1 in cycle 10.
REQ-034 digits using code 10 in place of 01 -> quotient identical to REQ-032/REQ-033 results.
REQ-035 start with divisor_zero=1 -> done and dbz=1 in cycle 1, quotient 0xFF, no load/iter_en; next start with divisor_zero=0 -> dbz=0.
REQ-036 start held high throughout -> operations back-to-back, IDLE for one cycle between DONE and LOAD, no start accepted while busy.
REQ-037 rst_n pulsed low during ITER cycle 5 -> all outputs 0 at once, no done; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/intdiv_ctrl_if.sv
// Handshake and status bundle between the SD2 divider datapath and its
// sequencing controller.
interface intdiv_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         divisor_zero;
    logic [1:0]   q_digit;
    logic         rem_sign;
    logic         load;
    logic         iter_en;
    logic         corr;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [N-1:0] quotient;

    // Datapath / requester side.
    modport master (
        output start, divisor_zero, q_digit, rem_sign,
        input  load, iter_en, corr, busy, done, dbz, quotient
    );

    // Controller side.
    modport slave (
        input  start, divisor_zero, q_digit, rem_sign,
        output load, iter_en, corr, busy, done, dbz, quotient
    );
endinterface

// File: rtl/intdiv_ctrl.sv
// Sequencer for an N-step SD2 (non-restoring style) integer divider.
// Converts the signed-digit quotient stream to two's complement on the fly
// (Q / QM pair) and applies the final remainder correction.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; divide-by-zero resolved directly to DONE
// LOAD   | one-cycle operand load strobe, conversion registers cleared
// ITER   | N iteration cycles, one quotient digit accepted per cycle
// FIX    | final remainder sign selects Q or QM, correction strobe
// DONE   | one-cycle completion pulse
module intdiv_ctrl #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    intdiv_ctrl_if.slave  bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic [N-1:0]  q_acc;
    logic [N-1:0]  qm_acc;
    logic [N-1:0]  quot_r;
    logic          load_r;
    logic          iter_r;
    logic          fix_r;
    logic          busy_r;
    logic          done_r;
    logic          dbz_r;

    assign cnt_last = (cnt == CW'(N - 1));

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = bus.divisor_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_ITER;
            S_ITER:  state_nxt = cnt_last ? S_FIX : S_ITER;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and strobes registered from the next-state decode, so
    // each strobe is a flop output aligned with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            load_r <= 1'b0;
            iter_r <= 1'b0;
            fix_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            load_r <= (state_nxt == S_LOAD);
            iter_r <= (state_nxt == S_ITER);
            fix_r  <= (state_nxt == S_FIX);
            busy_r <= (state_nxt == S_LOAD) || (state_nxt == S_ITER) ||
                      (state_nxt == S_FIX);
            done_r <= (state_nxt == S_DONE);
        end
    end

    // Step counter, on-the-fly Q/QM conversion, result and dbz capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            q_acc  <= '0;
            qm_acc <= '1;
            quot_r <= '0;
            dbz_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor_zero) begin
                            quot_r <= '1;
                            dbz_r  <= 1'b1;
                        end else begin
                            dbz_r  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    cnt    <= '0;
                    q_acc  <= '0;
                    qm_acc <= '1;
                end
                S_ITER: begin
                    cnt <= cnt + 1'b1;
                    case (bus.q_digit)
                        2'b11: begin
                            q_acc  <= {qm_acc[N-2:0], 1'b1};
                            qm_acc <= {qm_acc[N-2:0], 1'b0};
                        end
                        2'b00: begin
                            q_acc  <= {q_acc[N-2:0], 1'b0};
                            qm_acc <= {qm_acc[N-2:0], 1'b1};
                        end
                        default: begin
                            // 01 and 10 both encode +1.
                            q_acc  <= {q_acc[N-2:0], 1'b1};
                            qm_acc <= {q_acc[N-2:0], 1'b0};
                        end
                    endcase
                end
                S_FIX: begin
                    quot_r <= bus.rem_sign ? qm_acc : q_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.load     = load_r;
    assign bus.iter_en  = iter_r;
    // The final remainder sign only settles after the last iteration edge,
    // so the correction strobe is the registered FIX slot qualified by it.
    assign bus.corr     = fix_r & bus.rem_sign;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.dbz      = dbz_r;
    assign bus.quotient = quot_r;
endmodule

// File: tb/tb_intdiv_ctrl.sv
// Self-checking bench for intdiv_ctrl: timeline model of one operation,
// per-cycle output comparison, directed literal cases and random traffic.
module tb_intdiv_ctrl;
    localparam int N = 8;

    logic clk;
    logic rst_n;

    intdiv_ctrl_if #(.N(N)) bus ();

    intdiv_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model of the operation in flight, expressed as a timeline: cycle k
    // after the accepting edge (k = 1 is the first cycle after it).
    bit           op_valid = 1'b0;
    bit           op_dbz   = 1'b0;
    bit           op_rs    = 1'b0;
    int           op_base  = 0;
    logic [1:0]   op_codes [N];
    logic [N-1:0] op_result;
    logic [N-1:0] exp_quot = '0;
    logic         exp_dbz  = 1'b0;
    int           n_accepted = 0;
    int           acc_bases [$];

    // Requested stimulus for the next cycle.
    bit           want_start = 1'b0;
    bit           want_hold  = 1'b0;
    bit           want_dz    = 1'b0;
    bit           want_rs    = 1'b0;
    logic [1:0]   want_codes [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Arithmetic value of the signed-digit string, minus one when the
    // remainder needs correcting, reduced modulo 2^N.
    function automatic logic [N-1:0] calc_quot(input logic [1:0] cd [N], input bit rs);
        int v;
        v = 0;
        for (int i = 0; i < N; i++) begin
            if (cd[i] == 2'b11)      v = 2 * v - 1;
            else if (cd[i] == 2'b00) v = 2 * v;
            else                     v = 2 * v + 1;
        end
        if (rs) v = v - 1;
        return v[N-1:0];
    endfunction

    function automatic bit model_idle();
        if (!op_valid) return 1'b1;
        if (op_dbz)    return (cyc - op_base) >= 2;
        return (cyc - op_base) >= N + 4;
    endfunction

    task automatic rand_plan();
        for (int i = 0; i < N; i++) want_codes[i] = 2'($urandom);
        want_rs = 1'($urandom);
        want_dz = ($urandom_range(0, 5) == 0);
    endtask

    // Drive inputs for the current cycle and note an acceptance in the model.
    task automatic drive();
        int k;
        bus.start        = want_start;
        bus.divisor_zero = want_start ? want_dz : 1'($urandom);
        if (want_start && rst_n && model_idle()) begin
            op_valid  = 1'b1;
            op_base   = cyc;
            op_dbz    = want_dz;
            op_rs     = want_rs;
            op_codes  = want_codes;
            op_result = want_dz ? '1 : calc_quot(want_codes, want_rs);
            n_accepted++;
            acc_bases.push_back(cyc);
            if (!want_hold) want_start = 1'b0;
        end
        k = op_valid ? (cyc - op_base) : -1;
        if (op_valid && !op_dbz && k >= 2 && k <= N + 1) bus.q_digit = op_codes[k-2];
        else bus.q_digit = 2'($urandom);
        if (op_valid && !op_dbz && k == N + 2) bus.rem_sign = op_rs;
        else bus.rem_sign = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        drive();
    endtask

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        int   k;
        logic e_load, e_iter, e_corr, e_busy, e_done;
        k = (rst_n && op_valid) ? (cyc - op_base) : -1;
        e_load = 1'b0; e_iter = 1'b0; e_corr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (k >= 1) begin
            if (op_dbz) begin
                e_done = (k == 1);
                if (k == 1) begin
                    exp_dbz  = 1'b1;
                    exp_quot = '1;
                end
            end else begin
                e_load = (k == 1);
                e_iter = (k >= 2) && (k <= N + 1);
                e_corr = (k == N + 2) && op_rs;
                e_busy = (k >= 1) && (k <= N + 2);
                e_done = (k == N + 3);
                if (k == 1)     exp_dbz  = 1'b0;
                if (k == N + 3) exp_quot = op_result;
            end
        end
        check("load",     32'(bus.load),     32'(e_load));
        check("iter_en",  32'(bus.iter_en),  32'(e_iter));
        check("corr",     32'(bus.corr),     32'(e_corr));
        check("busy",     32'(bus.busy),     32'(e_busy));
        check("done",     32'(bus.done),     32'(e_done));
        check("dbz",      32'(bus.dbz),      32'(exp_dbz));
        check("quotient", 32'(bus.quotient), 32'(exp_quot));
    end

    task automatic check_all_zero(input string nm);
        check({nm, "_load"},  32'(bus.load),     32'd0);
        check({nm, "_iter"},  32'(bus.iter_en),  32'd0);
        check({nm, "_corr"},  32'(bus.corr),     32'd0);
        check({nm, "_busy"},  32'(bus.busy),     32'd0);
        check({nm, "_done"},  32'(bus.done),     32'd0);
        check({nm, "_dbz"},   32'(bus.dbz),      32'd0);
        check({nm, "_quot"},  32'(bus.quotient), 32'd0);
    endtask

    // One directed operation with hand-computed expectations.
    task automatic run_directed(input string nm, input logic [1:0] cd [N], input bit rs,
                                input bit dz, input logic [N-1:0] lit_q);
        int acc0, k, iters, loads, corr_k, done_k;
        bit got_done, corr_seen;
        want_codes = cd; want_rs = rs; want_dz = dz; want_hold = 1'b0; want_start = 1'b1;
        acc0 = n_accepted;
        for (int i = 0; i < 20 && n_accepted == acc0; i++) tick();
        check({nm, "_accepted"}, 32'(n_accepted - acc0), 32'd1);
        check({nm, "_model"}, 32'(op_result), 32'(lit_q));
        iters = 0; loads = 0; corr_k = -1; done_k = -1; got_done = 1'b0; corr_seen = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            tick();
            #1;
            k = cyc - op_base;
            if (bus.load) loads++;
            if (bus.iter_en) iters++;
            if (bus.corr) begin corr_seen = 1'b1; corr_k = k; end
            if (bus.done) begin got_done = 1'b1; done_k = k; end
        end
        check({nm, "_got_done"}, 32'(got_done), 32'd1);
        check({nm, "_done_cycle"}, 32'(done_k), dz ? 32'd1 : 32'd11);
        check({nm, "_iter_cnt"}, 32'(iters), dz ? 32'd0 : 32'd8);
        check({nm, "_load_cnt"}, 32'(loads), dz ? 32'd0 : 32'd1);
        check({nm, "_corr_seen"}, 32'(corr_seen), 32'(rs && !dz));
        if (rs && !dz) check({nm, "_corr_cycle"}, 32'(corr_k), 32'd10);
        check({nm, "_quot"}, 32'(bus.quotient), 32'(lit_q));
        check({nm, "_dbz"}, 32'(bus.dbz), 32'(dz));
        tick();
    endtask

    logic [1:0] cd_p1   [N];
    logic [1:0] cd_mix  [N];
    logic [1:0] cd_p1b  [N];
    logic [1:0] cd_mixb [N];

    initial begin
        int acc0;
        bus.start = 1'b0; bus.divisor_zero = 1'b0; bus.q_digit = 2'b00; bus.rem_sign = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) want_codes[i] = 2'b00;
        cd_p1   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        cd_p1b  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        cd_mix  = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        cd_mixb = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        #1;
        check_all_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        run_directed("all_plus",    cd_p1,   1'b0, 1'b0, 8'hFF);
        run_directed("mix_rs0",     cd_mix,  1'b0, 1'b0, 8'h41);
        run_directed("mix_rs1",     cd_mix,  1'b1, 1'b0, 8'h40);
        run_directed("all_plus_10", cd_p1b,  1'b0, 1'b0, 8'hFF);
        run_directed("mix_10_rs0",  cd_mixb, 1'b0, 1'b0, 8'h41);
        run_directed("mix_10_rs1",  cd_mixb, 1'b1, 1'b0, 8'h40);
        run_directed("div_zero",    cd_p1,   1'b0, 1'b1, 8'hFF);
        run_directed("after_dbz",   cd_mix,  1'b0, 1'b0, 8'h41);

        // Start held high: operations run back to back with one IDLE cycle.
        acc_bases.delete();
        want_hold = 1'b1; want_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_plan();
            want_dz = 1'b0;
            tick();
        end
        want_hold = 1'b0; want_start = 1'b0;
        check("hold_ops", 32'(acc_bases.size() >= 3), 32'd1);
        if (acc_bases.size() >= 3) begin
            check("hold_gap1", 32'(acc_bases[1] - acc_bases[0]), 32'd12);
            check("hold_gap2", 32'(acc_bases[2] - acc_bases[1]), 32'd12);
        end
        repeat (N + 5) tick();

        // Reset in ITER cycle 5 aborts the operation with no done pulse.
        rand_plan();
        want_dz = 1'b0; want_start = 1'b1;
        acc0 = n_accepted;
        for (int i = 0; i < 20 && n_accepted == acc0; i++) tick();
        check("rst_op_accepted", 32'(n_accepted - acc0), 32'd1);
        for (int i = 0; i < 12 && (cyc - op_base) != 6; i++) tick();
        check("rst_in_iter5", 32'(cyc - op_base), 32'd6);
        rst_n = 1'b0;
        op_valid = 1'b0; exp_quot = '0; exp_dbz = 1'b0;
        #1;
        check_all_zero("midop_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        run_directed("post_rst", cd_p1, 1'b0, 1'b0, 8'hFF);

        // Random traffic, including start requests while busy.
        for (int i = 0; i < 600; i++) begin
            rand_plan();
            want_start = ($urandom_range(0, 2) == 0);
            tick();
        end
        want_start = 1'b0;
        repeat (N + 6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
